// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// PMA checker for one OBI channel: checks each granted address phase against the
// region table, tracks outstanding transactions and pulses protocol/PMA violations.
package uvmt_cv32e40x_pma_obi_tracker_pkg;
  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        atomic;
  } pma_cfg_t;
endpackage

module uvmt_cv32e40x_pma_obi_tracker
  import uvmt_cv32e40x_pma_obi_tracker_pkg::*;
#(
  parameter int              ADDR_WIDTH      = 32,
  parameter bit              IS_INSTR_SIDE   = 1'b0,
  parameter int              PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t [15:0] PMA_CFG         = '0,
  parameter logic [ADDR_WIDTH-1:0] DM_REGION_START = '0,
  parameter logic [ADDR_WIDTH-1:0] DM_REGION_END   = '0,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              CNT_WIDTH       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    obi_req,
  input  logic                    obi_gnt,
  input  logic [ADDR_WIDTH-1:0]   obi_addr,
  input  logic                    obi_we,
  input  logic [1:0]              obi_memtype,
  input  logic                    obi_rvalid,
  input  logic                    dbg,
  input  logic                    misaligned_i,
  output logic [3:0]              outstanding_o,
  output logic                    rsp_valid_o,
  output logic [3:0]              rsp_match_idx_o,
  output logic                    err_denied_o,
  output logic                    err_memtype_o,
  output logic                    err_overflow_o,
  output logic                    err_underflow_o,
  output logic                    err_unstable_o,
  output logic [16*CNT_WIDTH-1:0] hit_cnt_o
);

  localparam int         CMP_W    = ADDR_WIDTH + 2;
  localparam logic [3:0] NO_MATCH = 4'd15;
  localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] LAST_PTR = 3'(MAX_OUTSTANDING - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic [3:0] idx;
    logic [1:0] memtype;
  } fifo_entry_t;

  function automatic logic region_hit(input logic [31:0] lo_w, input logic [31:0] hi_w,
                                      input logic [CMP_W-1:0] a);
    logic [CMP_W-1:0] lo;
    logic [CMP_W-1:0] hi;
    lo = CMP_W'({lo_w, 2'b00});
    hi = CMP_W'({hi_w, 2'b00});
    return (a >= lo) && (a < hi);
  endfunction

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST_PTR) ? 3'd0 : p + 3'd1;
  endfunction

  // State
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic                  cap_we_q, cap_we_d;
  logic [1:0]            cap_mt_q, cap_mt_d;
  fifo_entry_t           fifo_q [8];
  fifo_entry_t           fifo_d [8];
  logic [2:0]            wptr_q, wptr_d;
  logic [2:0]            rptr_q, rptr_d;
  logic [3:0]            count_q, count_d;
  logic [CNT_WIDTH-1:0]  hit_q [16];
  logic [CNT_WIDTH-1:0]  hit_d [16];
  logic                  rsp_valid_q, rsp_valid_d;
  logic [3:0]            rsp_idx_q, rsp_idx_d;
  logic                  err_denied_q, err_denied_d;
  logic                  err_memtype_q, err_memtype_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;
  logic                  err_unstable_q, err_unstable_d;

  // Address-phase evaluation
  logic       we_int;
  logic       accept;
  logic       in_dm;
  logic       match_found;
  logic [3:0] match_idx;
  logic       attr_main;
  logic       attr_buf;
  logic       attr_cach;
  logic       allow;
  logic [1:0] exp_memtype;
  fifo_entry_t head;
  logic [1:0]  unused_head_memtype;

  assign we_int = IS_INSTR_SIDE ? 1'b0 : obi_we;
  assign accept = obi_req && obi_gnt;
  assign in_dm  = dbg && (obi_addr >= DM_REGION_START) && (obi_addr <= DM_REGION_END);
  assign head   = fifo_q[rptr_q];
  assign unused_head_memtype = head.memtype;

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    match_found = 1'b0;
    match_idx   = NO_MATCH;
    for (int i = 15; i >= 0; i--) begin
      if ((i < PMA_NUM_REGIONS) &&
          region_hit(PMA_CFG[4'(i)].word_addr_low, PMA_CFG[4'(i)].word_addr_high,
                     CMP_W'(obi_addr))) begin
        match_found = 1'b1;
        match_idx   = 4'(i);
      end
    end
  end

  always_comb begin
    attr_main = (PMA_NUM_REGIONS == 0);
    attr_buf  = 1'b0;
    attr_cach = 1'b0;
    if (in_dm) begin
      attr_main = 1'b1;
    end else if (match_found) begin
      attr_main = PMA_CFG[match_idx].main;
      attr_buf  = PMA_CFG[match_idx].bufferable;
      attr_cach = PMA_CFG[match_idx].cacheable;
    end
    if (in_dm)              allow = 1'b1;
    else if (IS_INSTR_SIDE) allow = attr_main;
    else                    allow = attr_main || !misaligned_i;
    exp_memtype = {attr_cach, attr_buf && !IS_INSTR_SIDE && we_int};
  end

  // Address-phase stability FSM; fields are recaptured so each change pulses once
  always_comb begin
    state_d        = state_q;
    cap_addr_d     = cap_addr_q;
    cap_we_d       = cap_we_q;
    cap_mt_d       = cap_mt_q;
    err_unstable_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (obi_req && !obi_gnt) begin
          state_d    = ST_WAIT;
          cap_addr_d = obi_addr;
          cap_we_d   = we_int;
          cap_mt_d   = obi_memtype;
        end
      end
      ST_WAIT: begin
        if (obi_req) begin
          err_unstable_d = (obi_addr != cap_addr_q) || (we_int != cap_we_q) ||
                           (obi_memtype != cap_mt_q);
          cap_addr_d     = obi_addr;
          cap_we_d       = we_int;
          cap_mt_d       = obi_memtype;
          if (obi_gnt) state_d = ST_IDLE;
        end else begin
          err_unstable_d = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outstanding FIFO; an empty-FIFO response never pops a same-cycle grant
  always_comb begin
    logic do_push;
    fifo_d          = fifo_q;
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    count_d         = count_q;
    rsp_valid_d     = 1'b0;
    rsp_idx_d       = 4'd0;
    err_overflow_d  = 1'b0;
    err_underflow_d = 1'b0;
    do_push         = 1'b0;
    if (obi_rvalid && (count_q == 4'd0)) begin
      err_underflow_d = 1'b1;
      do_push         = accept;
    end else if (obi_rvalid) begin
      rsp_valid_d = 1'b1;
      rsp_idx_d   = head.idx;
      rptr_d      = ptr_inc(rptr_q);
      count_d     = count_q - 4'd1;
      do_push     = accept;
    end else if (accept) begin
      if (count_q == MAX_CNT) err_overflow_d = 1'b1;
      else                    do_push        = 1'b1;
    end
    if (do_push) begin
      fifo_d[wptr_q] = '{idx: match_idx, memtype: exp_memtype};
      wptr_d         = ptr_inc(wptr_q);
      count_d        = count_d + 4'd1;
    end
  end

  always_comb begin
    hit_d         = hit_q;
    err_denied_d  = accept && !allow;
    err_memtype_d = accept && (obi_memtype != exp_memtype);
    if (accept && match_found && (hit_q[match_idx] != '1)) begin
      hit_d[match_idx] = hit_q[match_idx] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cap_addr_q      <= '0;
      cap_we_q        <= 1'b0;
      cap_mt_q        <= 2'b00;
      fifo_q          <= '{default: '0};
      wptr_q          <= 3'd0;
      rptr_q          <= 3'd0;
      count_q         <= 4'd0;
      hit_q           <= '{default: '0};
      rsp_valid_q     <= 1'b0;
      rsp_idx_q       <= 4'd0;
      err_denied_q    <= 1'b0;
      err_memtype_q   <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_unstable_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cap_addr_q      <= cap_addr_d;
      cap_we_q        <= cap_we_d;
      cap_mt_q        <= cap_mt_d;
      fifo_q          <= fifo_d;
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      hit_q           <= hit_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_idx_q       <= rsp_idx_d;
      err_denied_q    <= err_denied_d;
      err_memtype_q   <= err_memtype_d;
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
      err_unstable_q  <= err_unstable_d;
    end
  end

  assign outstanding_o   = count_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_match_idx_o = rsp_idx_q;
  assign err_denied_o    = err_denied_q;
  assign err_memtype_o   = err_memtype_q;
  assign err_overflow_o  = err_overflow_q;
  assign err_underflow_o = err_underflow_q;
  assign err_unstable_o  = err_unstable_q;

  for (genvar g = 0; g < 16; g++) begin : g_hit_flat
    assign hit_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = hit_q[g];
  end

endmodule
